// File: rtl/shl_issue.sv
// Issue/retire stage for an external 32-bit combinational left barrel shifter:
// a request FIFO drives the shifter from its head, and a result register holds
// the shifted value with its tag and an overflow flag.
module shl_issue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic [5:0]    REQ_AMT,
  input  logic [31:0]   REQ_DATA,
  input  logic [3:0]    REQ_TAG,
  output logic [4:0]    SH_AMT,
  output logic [31:0]   SH_DIN,
  input  logic [31:0]   SH_DOUT,
  output logic          RES_VALID,
  input  logic          RES_READY,
  output logic [31:0]   RES_DATA,
  output logic [3:0]    RES_TAG,
  output logic          RES_OVF,
  output logic [CW-1:0] COUNT
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [5:0]  amt;
    logic [31:0] data;
    logic [3:0]  tag;
  } req_t;

  // Queue storage and bookkeeping
  req_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Result register
  logic          res_valid_q, res_valid_d;
  logic [31:0]   res_data_q,  res_data_d;
  logic [3:0]    res_tag_q,   res_tag_d;
  logic          res_ovf_q,   res_ovf_d;

  logic          push;
  logic          load;
  logic          empty;
  req_t          wr_entry;
  req_t          head;
  logic [31:0]   shifted;
  logic [63:0]   unshifted;

  assign empty     = (count_q == '0);
  assign REQ_READY = (count_q < FULL_CNT);
  assign push      = REQ_VALID & REQ_READY;
  assign load      = !empty & (!res_valid_q | RES_READY);

  assign wr_entry  = '{amt: REQ_AMT, data: REQ_DATA, tag: REQ_TAG};
  assign head      = mem_q[rd_ptr_q];

  // Shifter is driven purely from queue state so REQ_* never reaches RES_*.
  assign SH_AMT    = empty ? 5'd0  : head.amt[4:0];
  assign SH_DIN    = empty ? 32'd0 : head.data;

  // Amounts of 32..63 cannot be expressed by the shifter and yield zero.
  // Shifting back in 64 bits keeps the loss test valid for those amounts too.
  assign shifted   = head.amt[5] ? 32'd0 : SH_DOUT;
  assign unshifted = {32'd0, shifted} >> head.amt;

  // NOTE: queue storage has no reset; entries are only read while COUNT is
  // nonzero, so their power-up contents never become visible.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // NOTE: every variable is given a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    res_ovf_d   = res_ovf_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (load) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      res_valid_d = 1'b1;
      res_data_d  = shifted;
      res_tag_d   = head.tag;
      res_ovf_d   = (unshifted != {32'd0, head.data});
    end else if (res_valid_q && RES_READY) begin
      res_valid_d = 1'b0;
    end

    case ({push, load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= 32'd0;
      res_tag_q   <= 4'd0;
      res_ovf_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_data_q;
  assign RES_TAG   = res_tag_q;
  assign RES_OVF   = res_ovf_q;
  assign COUNT     = count_q;

endmodule

// File: tb/tb_shl_issue.sv
// Self-checking bench for shl_issue: models the shifter, keeps a scoreboard of
// expected results derived from the shift rules, and runs directed + random tests.
module tb_shl_issue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ_VALID;
  logic          REQ_READY;
  logic [5:0]    REQ_AMT;
  logic [31:0]   REQ_DATA;
  logic [3:0]    REQ_TAG;
  logic [4:0]    SH_AMT;
  logic [31:0]   SH_DIN;
  logic [31:0]   SH_DOUT;
  logic          RES_VALID;
  logic          RES_READY;
  logic [31:0]   RES_DATA;
  logic [3:0]    RES_TAG;
  logic          RES_OVF;
  logic [CW-1:0] COUNT;

  shl_issue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_AMT(REQ_AMT), .REQ_DATA(REQ_DATA), .REQ_TAG(REQ_TAG),
    .SH_AMT(SH_AMT), .SH_DIN(SH_DIN), .SH_DOUT(SH_DOUT),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_DATA(RES_DATA), .RES_TAG(RES_TAG), .RES_OVF(RES_OVF),
    .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  // The external barrel shifter is purely combinational.
  assign SH_DOUT = SH_DIN << SH_AMT;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        ovf;
  } res_t;

  // Reference: shift in 64 bits, anything landing above bit 31 is lost.
  function automatic res_t model(input logic [5:0] amt, input logic [31:0] data,
                                 input logic [3:0] tag);
    res_t        r;
    logic [63:0] wide;
    r.tag = tag;
    if (amt >= 6'd32) begin
      r.data = 32'd0;
      r.ovf  = (data != 32'd0);
    end else begin
      wide   = {32'd0, data} << amt;
      r.data = wide[31:0];
      r.ovf  = (wide[63:32] != 32'd0);
    end
    return r;
  endfunction

  res_t        exp_q[$];
  int          results_seen = 0;
  int          accepted     = 0;
  int          max_count    = 0;
  int          cyc_cnt      = 0;
  logic        hold_v       = 1'b0;
  logic [36:0] hold_val;

  always @(posedge CLK) cyc_cnt++;

  // Monitor: handshakes are sampled on the falling edge, ahead of the rising
  // edge at which they take effect.
  always @(negedge CLK) begin
    res_t e;
    if (RST) begin
      hold_v = 1'b0;
    end else begin
      if (int'(COUNT) > max_count) max_count = int'(COUNT);
      check("req_ready_vs_count", REQ_READY, (int'(COUNT) < DEPTH));
      if (COUNT == '0) check("sh_idle", {SH_AMT, SH_DIN}, 37'd0);
      if (hold_v) check("res_stable", {RES_DATA, RES_TAG, RES_OVF}, hold_val);
      hold_v   = RES_VALID && !RES_READY;
      hold_val = {RES_DATA, RES_TAG, RES_OVF};
      if (REQ_VALID && REQ_READY) begin
        exp_q.push_back(model(REQ_AMT, REQ_DATA, REQ_TAG));
        accepted++;
      end
      if (RES_VALID && RES_READY) begin
        if (exp_q.size() == 0) begin
          check("res_spurious", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", RES_DATA, e.data);
          check("sb_tag",  RES_TAG,  e.tag);
          check("sb_ovf",  RES_OVF,  e.ovf);
        end
        results_seen++;
      end
    end
  end

  task automatic push_one(input logic [5:0] amt, input logic [31:0] data,
                          input logic [3:0] tag);
    bit done = 1'b0;
    REQ_VALID = 1'b1;
    REQ_AMT   = amt;
    REQ_DATA  = data;
    REQ_TAG   = tag;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLK);
      done = REQ_READY;
      @(posedge CLK);
      #1;
    end
    REQ_VALID = 1'b0;
    if (!done) check("push_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((COUNT != '0 || RES_VALID) && n < 60) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("drain", (COUNT == '0 && !RES_VALID), 1);
  endtask

  task automatic one_shot(input string name, input logic [5:0] amt,
                          input logic [31:0] data, input logic [3:0] tag,
                          input logic [31:0] exp_data, input logic exp_ovf);
    int waited = 0;
    push_one(amt, data, tag);
    while (!RES_VALID && waited < 10) begin
      @(posedge CLK);
      #1;
      waited++;
    end
    check({name, "_valid"}, RES_VALID, 1);
    check({name, "_data"},  RES_DATA,  exp_data);
    check({name, "_tag"},   RES_TAG,   tag);
    check({name, "_ovf"},   RES_OVF,   exp_ovf);
    drain();
  endtask

  initial begin
    int          t;
    int          base_acc;
    int          base_res;
    int          cyc_start;
    bit          acc;
    logic [5:0]  a;
    logic [31:0] d;

    RST       = 1'b1;
    REQ_VALID = 1'b0;
    REQ_AMT   = '0;
    REQ_DATA  = '0;
    REQ_TAG   = '0;
    RES_READY = 1'b1;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_count",     COUNT,     0);
    check("rst_req_ready", REQ_READY, 1);
    check("rst_res_valid", RES_VALID, 0);
    check("rst_res_data",  RES_DATA,  0);
    check("rst_res_tag",   RES_TAG,   0);
    check("rst_res_ovf",   RES_OVF,   0);
    #1 RST = 1'b0;
    @(posedge CLK);
    #1;

    // Basic shift with two-edge latency
    push_one(6'd4, 32'h0000_00FF, 4'd3);
    check("basic_no_bypass", RES_VALID, 0);
    check("basic_count",     COUNT,     1);
    @(posedge CLK);
    #1;
    check("basic_valid", RES_VALID, 1);
    check("basic_data",  RES_DATA,  32'h0000_0FF0);
    check("basic_tag",   RES_TAG,   3);
    check("basic_ovf",   RES_OVF,   0);
    drain();

    // Overflow and out-of-range amounts
    one_shot("ovf",    6'd8,  32'hFF00_0001, 4'd5,  32'h0000_0100, 1'b1);
    one_shot("amt40",  6'd40, 32'h0000_0001, 4'd6,  32'd0,         1'b1);
    one_shot("amt32",  6'd32, 32'h0000_0000, 4'd7,  32'd0,         1'b0);
    one_shot("amt0",   6'd0,  32'hDEAD_BEEF, 4'd8,  32'hDEAD_BEEF, 1'b0);
    one_shot("amt31",  6'd31, 32'h0000_0003, 4'd9,  32'h8000_0000, 1'b1);
    one_shot("amt63",  6'd63, 32'h0000_0000, 4'd10, 32'd0,         1'b0);

    // Backpressure / full queue
    RES_READY = 1'b0;
    t         = 0;
    base_acc  = accepted;
    base_res  = results_seen;
    REQ_VALID = 1'b1;
    REQ_AMT   = 6'($urandom_range(0, 63));
    REQ_DATA  = $urandom;
    REQ_TAG   = 4'(t);
    for (int cyc = 0; cyc < 60 && (t < 8 || exp_q.size() != 0); cyc++) begin
      @(negedge CLK);
      acc = REQ_VALID && REQ_READY;
      @(posedge CLK);
      #1;
      if (acc) begin
        t++;
        if (t < 8) begin
          REQ_AMT  = 6'($urandom_range(0, 63));
          REQ_DATA = $urandom;
          REQ_TAG  = 4'(t);
        end else begin
          REQ_VALID = 1'b0;
        end
      end
      if (cyc == 12) begin
        check("full_accepted",  accepted - base_acc, 5);
        check("full_count",     COUNT,     4);
        check("full_req_ready", REQ_READY, 0);
        check("full_res_valid", RES_VALID, 1);
        check("full_res_tag",   RES_TAG,   0);
        check("full_no_retire", results_seen - base_res, 0);
        base_res  = results_seen;
        RES_READY = 1'b1;
      end
      if (cyc == 17) check("full_drain_rate", results_seen - base_res, 5);
    end
    check("full_all_accepted", t, 8);
    drain();

    // Streaming with pointer wrap
    RES_READY = 1'b1;
    max_count = 0;
    base_res  = results_seen;
    cyc_start = cyc_cnt;
    for (int i = 0; i < 20; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31));
      d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      push_one(a, d, 4'(i));
    end
    check("stream_cycles", cyc_cnt - cyc_start, 20);
    drain();
    check("stream_results",   results_seen - base_res, 20);
    check("stream_max_count", (max_count <= 1), 1);

    // Reset mid-operation
    RES_READY = 1'b0;
    for (int i = 0; i < 4; i++) push_one(6'(i + 1), 32'h1111_0000 + 32'(i), 4'(i));
    check("mid_count",     COUNT,     3);
    check("mid_res_valid", RES_VALID, 1);
    @(posedge CLK);
    #3 RST = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_res_valid", RES_VALID, 0);
    check("mid_rst_count",     COUNT,     0);
    check("mid_rst_req_ready", REQ_READY, 1);
    @(negedge CLK);
    @(negedge CLK);
    #2 RST = 1'b0;
    RES_READY = 1'b1;
    @(posedge CLK);
    #1;
    base_res = results_seen;
    one_shot("post_rst", 6'd1, 32'h8000_0000, 4'd12, 32'd0, 1'b1);
    repeat (5) @(posedge CLK);
    #1;
    check("post_rst_results", results_seen - base_res, 1);
    check("post_rst_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
